// File: rtl/data_io_sync.sv
// SPI download port: oversamples sck/ss/sdi in clk_sys and packs payload bytes
// into words, presenting each through a single-entry valid/ready holding register.
module data_io_sync #(
    parameter int START_ADDR  = 0,
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   sck,
    input  logic                   ss,
    input  logic                   sdi,
    output logic                   downloading,
    output logic [INDEX_WIDTH-1:0] ioctl_index,
    output logic                   ioctl_wr,
    input  logic                   ioctl_ready,
    output logic [ADDR_WIDTH-1:0]  ioctl_addr,
    output logic [DATA_WIDTH-1:0]  ioctl_dout,
    output logic                   overflow
);

    localparam logic [7:0] CMD_FILE_TX     = 8'h53;
    localparam logic [7:0] CMD_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;
    localparam logic [ADDR_WIDTH-1:0] ADDR_RST = ADDR_WIDTH'(START_ADDR);
    localparam logic LANE_LAST = (DATA_WIDTH == 16);

    logic [1:0] sck_sync_q, ss_sync_q, sdi_sync_q;
    logic       sck_prev_q;

    logic [2:0]             bit_q, bit_d;
    logic [6:0]             shift_q, shift_d;
    logic                   have_cmd_q, have_cmd_d;
    logic [7:0]             cmd_q, cmd_d;
    logic                   lane_q, lane_d;
    logic [7:0]             low_q, low_d;
    logic                   dl_q, dl_d;
    logic                   end_pend_q, end_pend_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic                   wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic                   ovf_q, ovf_d;

    logic                   sck_s, ss_s, sdi_s, sck_rise, byte_done, accept;
    logic [7:0]             byte_in;
    logic [INDEX_WIDTH+7:0] idx_ext;
    logic [DATA_WIDTH-1:0]  word;

    assign sck_s    = sck_sync_q[1];
    assign ss_s     = ss_sync_q[1];
    assign sdi_s    = sdi_sync_q[1];
    assign sck_rise = sck_s & ~sck_prev_q & ~ss_s;
    assign byte_in  = {shift_q, sdi_s};
    assign idx_ext  = {{INDEX_WIDTH{1'b0}}, byte_in};
    assign accept   = wr_q & ioctl_ready;

    // The final byte of a word is used straight from the shifter so the write
    // request leaves one edge after the last synchronised sck rise.
    if (DATA_WIDTH == 16) begin : g_w16
        assign word = {byte_in, low_q};
    end else begin : g_w8
        assign word = byte_in;
        logic unused_low;
        assign unused_low = ^low_q;
    end

    always_comb begin
        bit_d      = bit_q;
        shift_d    = shift_q;
        have_cmd_d = have_cmd_q;
        cmd_d      = cmd_q;
        lane_d     = lane_q;
        low_d      = low_q;
        dl_d       = dl_q;
        end_pend_d = end_pend_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        ovf_d      = ovf_q;
        byte_done  = 1'b0;

        if (end_pend_q && !wr_q) begin
            dl_d       = 1'b0;
            end_pend_d = 1'b0;
        end
        if (accept) begin
            wr_d   = 1'b0;
            addr_d = addr_q + 1'b1;
        end

        if (ss_s) begin
            bit_d      = 3'd0;
            lane_d     = 1'b0;
            have_cmd_d = 1'b0;
            cmd_d      = 8'h00;
        end else if (sck_rise) begin
            shift_d   = byte_in[6:0];
            bit_d     = bit_q + 3'd1;
            byte_done = (bit_q == 3'd7);
        end

        if (byte_done) begin
            if (!have_cmd_q) begin
                cmd_d      = byte_in;
                have_cmd_d = 1'b1;
            end else begin
                case (cmd_q)
                    CMD_FILE_TX: begin
                        if (byte_in[0]) begin
                            dl_d       = 1'b1;
                            addr_d     = ADDR_RST;
                            ovf_d      = 1'b0;
                            lane_d     = 1'b0;
                            end_pend_d = 1'b0;
                        end else if (wr_d) begin
                            end_pend_d = 1'b1;
                        end else begin
                            dl_d       = 1'b0;
                            end_pend_d = 1'b0;
                        end
                    end
                    CMD_FILE_INDEX: begin
                        if (!dl_q) idx_d = idx_ext[INDEX_WIDTH-1:0];
                    end
                    CMD_FILE_TX_DAT: begin
                        if (dl_q) begin
                            if (lane_q == LANE_LAST) begin
                                lane_d = 1'b0;
                                if (!wr_q || accept) begin
                                    dout_d = word;
                                    wr_d   = 1'b1;
                                end else begin
                                    ovf_d = 1'b1;
                                end
                            end else begin
                                low_d  = byte_in;
                                lane_d = ~lane_q;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q <= 2'b00;
            ss_sync_q  <= 2'b11;
            sdi_sync_q <= 2'b00;
            sck_prev_q <= 1'b0;
            bit_q      <= 3'd0;
            shift_q    <= 7'd0;
            have_cmd_q <= 1'b0;
            cmd_q      <= 8'h00;
            lane_q     <= 1'b0;
            low_q      <= 8'h00;
            dl_q       <= 1'b0;
            end_pend_q <= 1'b0;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= ADDR_RST;
            dout_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[0], sck};
            ss_sync_q  <= {ss_sync_q[0], ss};
            sdi_sync_q <= {sdi_sync_q[0], sdi};
            sck_prev_q <= sck_s;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            have_cmd_q <= have_cmd_d;
            cmd_q      <= cmd_d;
            lane_q     <= lane_d;
            low_q      <= low_d;
            dl_q       <= dl_d;
            end_pend_q <= end_pend_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            ovf_q      <= ovf_d;
        end
    end

    assign downloading = dl_q;
    assign ioctl_index = idx_q;
    assign ioctl_wr    = wr_q;
    assign ioctl_addr  = addr_q;
    assign ioctl_dout  = dout_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_data_io_sync.sv
// Directed bench for data_io_sync: 8-bit, 16-bit and 4-bit-address instances on a shared SPI bus.
module tb_data_io_sync;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sck = 1'b0, sdi = 1'b0;
    logic ss8 = 1'b1, ss16 = 1'b1, ss4 = 1'b1;
    logic r8 = 1'b1, r16 = 1'b1, r4 = 1'b1;

    logic        dl8, wr8, ovf8;
    logic [7:0]  idx8, dout8;
    logic [11:0] addr8;
    logic        dl16, wr16, ovf16;
    logic [7:0]  idx16;
    logic [15:0] dout16;
    logic [11:0] addr16;
    logic        dl4, wr4, ovf4;
    logic [7:0]  idx4, dout4;
    logic [3:0]  addr4;

    int tests = 0, fails = 0;
    int qa8[$], qd8[$], qa16[$], qd16[$], qa4[$], qd4[$];
    int wrcyc8 = 0;
    logic [7:0] fb[$];

    always #5 clk = ~clk;

    data_io_sync #(.START_ADDR(0), .ADDR_WIDTH(12), .DATA_WIDTH(8), .INDEX_WIDTH(8)) u8 (
        .clk_sys(clk), .reset_n(reset_n), .sck(sck), .ss(ss8), .sdi(sdi),
        .downloading(dl8), .ioctl_index(idx8), .ioctl_wr(wr8), .ioctl_ready(r8),
        .ioctl_addr(addr8), .ioctl_dout(dout8), .overflow(ovf8));

    data_io_sync #(.START_ADDR(0), .ADDR_WIDTH(12), .DATA_WIDTH(16), .INDEX_WIDTH(8)) u16 (
        .clk_sys(clk), .reset_n(reset_n), .sck(sck), .ss(ss16), .sdi(sdi),
        .downloading(dl16), .ioctl_index(idx16), .ioctl_wr(wr16), .ioctl_ready(r16),
        .ioctl_addr(addr16), .ioctl_dout(dout16), .overflow(ovf16));

    data_io_sync #(.START_ADDR(0), .ADDR_WIDTH(4), .DATA_WIDTH(8), .INDEX_WIDTH(8)) u4 (
        .clk_sys(clk), .reset_n(reset_n), .sck(sck), .ss(ss4), .sdi(sdi),
        .downloading(dl4), .ioctl_index(idx4), .ioctl_wr(wr4), .ioctl_ready(r4),
        .ioctl_addr(addr4), .ioctl_dout(dout4), .overflow(ovf4));

    // Accepted writes are logged on the falling edge; ready only changes just after a rising edge.
    always @(negedge clk) begin
        if (wr8) wrcyc8++;
        if (wr8 && r8) begin qa8.push_back(int'(addr8)); qd8.push_back(int'(dout8)); end
        if (wr16 && r16) begin qa16.push_back(int'(addr16)); qd16.push_back(int'(dout16)); end
        if (wr4 && r4) begin qa4.push_back(int'(addr4)); qd4.push_back(int'(dout4)); end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_ss(input int sel, input logic v);
        case (sel)
            8:  ss8 = v;
            16: ss16 = v;
            default: ss4 = v;
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sdi = b[i];
            #50 sck = 1'b1;
            #50 sck = 1'b0;
        end
    endtask

    task automatic frame(input int sel);
        set_ss(sel, 1'b0);
        #100;
        foreach (fb[i]) send_byte(fb[i]);
        #100;
        set_ss(sel, 1'b1);
        #200;
    endtask

    task automatic set_r8(input logic v);
        @(posedge clk);
        #1 r8 = v;
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  dat;
        logic        dl;
        logic [7:0]  idx;
        int          nw;
        int          a;
        int          d;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int n0, w0;
        logic stable;

        tbl[0] = '{8'h55, 8'h07, 1'b0, 8'h07, 0, 0, 0};
        tbl[1] = '{8'h53, 8'h01, 1'b1, 8'h07, 0, 0, 0};
        tbl[2] = '{8'h54, 8'hAA, 1'b1, 8'h07, 1, 0, 'hAA};
        tbl[3] = '{8'h54, 8'h55, 1'b1, 8'h07, 1, 1, 'h55};
        tbl[4] = '{8'h54, 8'h12, 1'b1, 8'h07, 1, 2, 'h12};
        tbl[5] = '{8'h55, 8'h09, 1'b1, 8'h07, 0, 0, 0};
        tbl[6] = '{8'h53, 8'h00, 1'b0, 8'h07, 0, 0, 0};
        tbl[7] = '{8'h54, 8'h33, 1'b0, 8'h07, 0, 0, 0};
        tbl[8] = '{8'h55, 8'h09, 1'b0, 8'h09, 0, 0, 0};

        #23 reset_n = 1'b1;
        #50;
        chk("rst_dl", dl8, 0);
        chk("rst_wr", wr8, 0);
        chk("rst_addr", addr8, 0);
        chk("rst_ovf", ovf8, 0);
        chk("rst_idx", idx8, 0);

        for (int v = 0; v < 9; v++) begin
            n0 = qa8.size();
            fb = {tbl[v].cmd, tbl[v].dat};
            frame(8);
            chk($sformatf("vec%0d_dl", v), dl8, tbl[v].dl);
            chk($sformatf("vec%0d_idx", v), idx8, tbl[v].idx);
            chk($sformatf("vec%0d_nw", v), qa8.size() - n0, tbl[v].nw);
            if (tbl[v].nw > 0) begin
                chk($sformatf("vec%0d_addr", v), qa8[$], tbl[v].a);
                chk($sformatf("vec%0d_data", v), qd8[$], tbl[v].d);
            end
        end

        // One frame carrying three bytes, ready tied high.
        fb = {8'h53, 8'h01};
        frame(8);
        chk("seq_dl_on", dl8, 1);
        n0 = qa8.size();
        w0 = wrcyc8;
        fb = {8'h54, 8'hAA, 8'h55, 8'h12};
        frame(8);
        chk("seq_nw", qa8.size() - n0, 3);
        chk("seq_pulse_cycles", wrcyc8 - w0, 3);
        chk("seq_a0", qa8[n0], 0);   chk("seq_d0", qd8[n0], 'hAA);
        chk("seq_a1", qa8[n0+1], 1); chk("seq_d1", qd8[n0+1], 'h55);
        chk("seq_a2", qa8[n0+2], 2); chk("seq_d2", qd8[n0+2], 'h12);
        chk("seq_dl_mid", dl8, 1);
        fb = {8'h53, 8'h00};
        frame(8);
        chk("seq_dl_off", dl8, 0);

        // Backpressure: second word dropped, first held stable.
        fb = {8'h53, 8'h01};
        frame(8);
        set_r8(1'b0);
        n0 = qa8.size();
        fb = {8'h54, 8'hA1, 8'hB2};
        frame(8);
        chk("ovf_wr", wr8, 1);
        chk("ovf_dout", dout8, 'hA1);
        chk("ovf_addr", addr8, 0);
        chk("ovf_flag", ovf8, 1);
        stable = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!(wr8 === 1'b1 && dout8 === 8'hA1 && addr8 === 12'h000)) stable = 1'b0;
        end
        chk("ovf_hold_stable", stable, 1);
        set_r8(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_nw", qa8.size() - n0, 1);
        chk("ovf_acc_data", qd8[$], 'hA1);
        chk("ovf_acc_addr", qa8[$], 0);
        chk("ovf_wr_low", wr8, 0);
        chk("ovf_addr_inc", addr8, 1);
        chk("ovf_sticky", ovf8, 1);
        fb = {8'h53, 8'h01};
        frame(8);
        chk("ovf_cleared", ovf8, 0);
        chk("ovf_addr_rst", addr8, 0);

        // End request while a write is still pending.
        set_r8(1'b0);
        fb = {8'h54, 8'hC3};
        frame(8);
        fb = {8'h53, 8'h00};
        frame(8);
        chk("end_pend_dl", dl8, 1);
        chk("end_pend_wr", wr8, 1);
        set_r8(1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("end_dl_fall", dl8, 0);
        chk("end_last_data", qd8[$], 'hC3);

        // Asynchronous reset while a write is pending and overflow is set.
        fb = {8'h53, 8'h01};
        frame(8);
        set_r8(1'b0);
        fb = {8'h54, 8'h5A, 8'h6B};
        frame(8);
        chk("prerst_wr", wr8, 1);
        chk("prerst_ovf", ovf8, 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #2;
        chk("mrst_dl", dl8, 0);
        chk("mrst_idx", idx8, 0);
        chk("mrst_wr", wr8, 0);
        chk("mrst_addr", addr8, 0);
        chk("mrst_dout", dout8, 0);
        chk("mrst_ovf", ovf8, 0);
        #20 reset_n = 1'b1;
        n0 = qa8.size();
        set_r8(1'b1);
        repeat (20) @(posedge clk);
        #1;
        chk("mrst_no_write", qa8.size() - n0, 0);

        // 16-bit packing and partial-word discard.
        fb = {8'h53, 8'h01};
        frame(16);
        fb = {8'h54, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h77};
        frame(16);
        chk("w16_nw", qa16.size(), 2);
        if (qa16.size() >= 2) begin
            chk("w16_a0", qa16[0], 0); chk("w16_d0", qd16[0], 'h1234);
            chk("w16_a1", qa16[1], 1); chk("w16_d1", qd16[1], 'hABCD);
        end
        chk("w16_ovf", ovf16, 0);
        fb = {8'h54, 8'h11, 8'h22};
        frame(16);
        chk("w16_nw2", qa16.size(), 3);
        if (qa16.size() >= 3) begin
            chk("w16_a2", qa16[2], 2); chk("w16_d2", qd16[2], 'h2211);
        end

        // 4-bit address wrap over 17 bytes.
        fb = {8'h53, 8'h01};
        frame(4);
        fb = {8'h54};
        for (int i = 0; i < 17; i++) fb.push_back(8'(8'h10 + i));
        frame(4);
        chk("a4_nw", qa4.size(), 17);
        if (qa4.size() == 17) begin
            for (int i = 0; i < 17; i++) begin
                chk($sformatf("a4_addr%0d", i), qa4[i], i % 16);
                chk($sformatf("a4_data%0d", i), qd4[i], 'h10 + i);
            end
        end
        chk("a4_addr_final", addr4, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_io_sync.md
Name: data_io_sync

Overview:
- Parametrised successor to the SPI download port.
- Receives file data from the IO controller over the slave SPI link (sck/ss/sdi) and oversamples it in the core clock domain.
- Assembles bytes into DATA_WIDTH-bit words and presents them to core RAM through a valid/ready write handshake with a single holding register.
- Adds a file-index command and a sticky overflow flag.

Parameters:
- START_ADDR, 0, word address loaded at download start.
- ADDR_WIDTH, 12, width of ioctl_addr.
- DATA_WIDTH, 8, word width; legal values 8 or 16 only.
- INDEX_WIDTH, 8, width of ioctl_index.

Ports:
- clk_sys  in  1  core clock; all logic on rising edge; must be at least 4x sck frequency.
- reset_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock from IO controller, asynchronous to clk_sys.
- ss  in  1  SPI select, active-low.
- sdi  in  1  SPI data, MSB first, sampled on sck rising edge.
- downloading  out  1  download in progress.
- ioctl_index  out  INDEX_WIDTH  last file index received.
- ioctl_wr  out  1  write request, valid.
- ioctl_ready  in  1  RAM accepts the write this cycle.
- ioctl_addr  out  ADDR_WIDTH  word address of the pending write.
- ioctl_dout  out  DATA_WIDTH  word data of the pending write.
- overflow  out  1  sticky: a word was dropped.

Behaviour:
- Reset (reset_n low, asynchronous): downloading=0, ioctl_index=0, ioctl_wr=0, ioctl_addr=START_ADDR, ioctl_dout=0, overflow=0. Bit/byte counters, cmd and synchronisers clear. Applies mid-transfer; the transfer in flight is abandoned.
- Input capture:
  - sck, ss and sdi each pass through a 2-FF synchroniser.
  - An sck rise is a cycle where synchronised sck=1 and its previous value=0; each sck rise while synchronised ss=0 shifts in one sdi bit.
- Framing:
  - Synchronised ss high clears the bit counter, byte-lane counter and cmd.
  - First byte after ss falls = cmd; all following bytes = payload.
  - The 3-bit counter wraps every 8 bits.
- cmd 0x53 (FILE_TX), per payload byte:
  - bit0=1: downloading=1, ioctl_addr=START_ADDR, overflow=0, byte lane=0.
  - bit0=0: end request. downloading falls on the cycle the holding register is empty (immediately if already empty).
- cmd 0x55 (FILE_INDEX): each payload byte loads ioctl_index (zero-extended or truncated to INDEX_WIDTH). Ignored while downloading=1.
- cmd 0x54 (FILE_TX_DAT):
  - Payload bytes are packed little-endian; first byte goes in bits [7:0].
  - A word is complete after DATA_WIDTH/8 bytes.
  - Bytes received while downloading=0 are discarded.
- Holding register and handshake:
  - On word completion with ioctl_wr=0: load ioctl_dout, set ioctl_wr=1 on the next clk_sys edge.
  - ioctl_wr rises no later than 4 clk_sys cycles after the sck pin edge carrying the last bit.
  - ioctl_wr, ioctl_addr and ioctl_dout stay stable until a cycle with ioctl_wr=1 and ioctl_ready=1.
  - On that cycle: ioctl_wr=0 next edge, and ioctl_addr increments by 1 modulo 2^ADDR_WIDTH (wraps to 0).
  - On word completion with ioctl_wr=1 and no acceptance that same cycle: new word dropped, overflow=1, address not advanced.
  - Acceptance and completion in the same cycle: the register reloads with the new word and ioctl_wr stays 1, no overflow.
- ss rising mid-word: partial bytes discarded, not written. A pending write is unaffected.
- Unknown cmd values: payload ignored.

Test Plan:
- Reset mid-write: ioctl_wr=1, pulse reset_n low -> all outputs at reset values, ioctl_addr=START_ADDR, no further write.
- DATA_WIDTH=8, ioctl_ready tied 1. Send 0x53/0x01, then 0x54 with AA 55 12, then 0x53/0x00 -> three single-cycle ioctl_wr pulses (AA@0x000, 55@0x001, 12@0x002); downloading=1 throughout, falls after the end byte.
- DATA_WIDTH=16. Send 0x54 with 34 12 CD AB 77, then ss high -> writes 0x1234@0, 0xABCD@1; byte 0x77 dropped; overflow=0.
- ioctl_ready held 0 for 40 sck periods while two words arrive -> first word held stable, second dropped, overflow=1. A new 0x53/0x01 clears overflow.
- ADDR_WIDTH=4, 17 bytes written -> addresses 0..15 then 0; byte 17 at address 0.
- 0x55/0x07 with downloading=0 -> ioctl_index=7. The same sent while downloading=1 -> ioctl_index unchanged.
